// File: rtl/wb_master.sv
// Single-beat Wishbone master bridging a valid/ready request port to a
// valid/ready response port; one transaction in flight, with a bus timeout.
module wb_master #(
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int sel_width  = data_width / 8,
  parameter int timeout    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  // request side
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [addr_width-1:0] req_addr,
  input  logic [data_width-1:0] req_data,
  input  logic [sel_width-1:0]  req_sel,
  // response side
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [data_width-1:0] resp_data,
  output logic                  resp_err,
  // Wishbone side
  output logic [addr_width-1:0] wb_adr,
  output logic [data_width-1:0] wb_datwr,
  input  logic [data_width-1:0] wb_datrd,
  output logic                  wb_we,
  output logic [sel_width-1:0]  wb_sel,
  output logic                  wb_stb,
  output logic                  wb_cyc,
  input  logic                  wb_ack
);

  localparam int CW = $clog2(timeout) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(timeout - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Every output is a register updated alongside the state, so nothing
  // on the request or Wishbone inputs reaches an output combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      wb_cyc     <= 1'b0;
      wb_stb     <= 1'b0;
      wb_we      <= 1'b0;
      wb_adr     <= '0;
      wb_datwr   <= '0;
      wb_sel     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wb_adr    <= req_addr;
            wb_datwr  <= req_data;
            wb_sel    <= req_sel;
            wb_we     <= req_we;
            cnt       <= '0;
            req_ready <= 1'b0;
            wb_cyc    <= 1'b1;
            wb_stb    <= 1'b1;
            state     <= BUS;
          end
        end
        BUS: begin
          // ack is checked first so it wins over a coincident timeout
          if (wb_ack) begin
            resp_data  <= wb_we ? '0 : wb_datrd;
            resp_err   <= 1'b0;
            wb_cyc     <= 1'b0;
            wb_stb     <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (cnt == TO_LAST) begin
            resp_data  <= '0;
            resp_err   <= 1'b1;
            wb_cyc     <= 1'b0;
            wb_stb     <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          req_ready  <= 1'b1;
          wb_cyc     <= 1'b0;
          wb_stb     <= 1'b0;
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master.sv
// Directed bench for wb_master against a one-cycle-ack memory responder.
module tb_wb_master;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_data = '0;
  logic [3:0]  req_sel = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_data;
  logic [31:0] wb_adr, wb_datwr, wb_datrd;
  logic        wb_we, wb_stb, wb_cyc, wb_ack;
  logic [3:0]  wb_sel;

  int checks = 0;
  int errors = 0;

  wb_master #(.addr_width(32), .data_width(32), .sel_width(4), .timeout(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data), .req_sel(req_sel),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .wb_adr(wb_adr), .wb_datwr(wb_datwr), .wb_datrd(wb_datrd), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
  );

  always #5 clock = ~clock;

  // responder: registered ack one cycle after stb, small byte-lane memory
  logic        ack_en = 1'b1;
  logic        stray = 1'b0;
  logic        ack_reg = 1'b0;
  logic [31:0] mem [16];
  assign wb_ack   = ack_reg | stray;
  assign wb_datrd = mem[wb_adr[5:2]];

  always @(posedge clock) begin
    if (reset) ack_reg <= 1'b0;
    else begin
      ack_reg <= ack_en && wb_cyc && wb_stb && !ack_reg;
      if (ack_reg && wb_cyc && wb_stb && wb_we)
        for (int b = 0; b < 4; b++)
          if (wb_sel[b]) mem[wb_adr[5:2]][b*8 +: 8] <= wb_datwr[b*8 +: 8];
    end
  end

  // strobe activity monitor
  logic stb_prev = 1'b0;
  int   stb_hi = 0;
  int   stb_pulses = 0;
  always @(posedge clock) begin
    stb_prev <= wb_stb;
    if (wb_stb) stb_hi <= stb_hi + 1;
    if (wb_stb && !stb_prev) stb_pulses <= stb_pulses + 1;
  end

  // present one request; returns #1 after its accept edge
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clock);
    req_we = we; req_addr = a; req_data = d; req_sel = s; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  // full transaction with bounded wait; lat = edges after accept until resp_valid seen
  task automatic run_txn(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd, output logic er, output int lat, output bit got);
    issue(we, a, d, s);
    lat = 0;
    for (int i = 0; i < 64; i++) begin
      if (resp_valid) break;
      @(posedge clock); #1;
      lat++;
    end
    got = resp_valid;
    rd  = resp_data;
    er  = resp_err;
    @(negedge clock); resp_ready = 1'b1;
    @(posedge clock); #1;
    @(negedge clock); resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++;
      $display("FAIL reset_handshake got ready=%0b rvalid=%0b exp 1 0", req_ready, resp_valid); end
    checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_we !== 1'b0) begin errors++;
      $display("FAIL reset_wb_ctl got cyc=%0b stb=%0b we=%0b exp 0 0 0", wb_cyc, wb_stb, wb_we); end
    checks++; if (wb_adr !== 32'h0 || wb_datwr !== 32'h0 || wb_sel !== 4'h0) begin errors++;
      $display("FAIL reset_wb_bus got adr=%h dat=%h sel=%h exp 0", wb_adr, wb_datwr, wb_sel); end
    checks++; if (resp_data !== 32'h0 || resp_err !== 1'b0) begin errors++;
      $display("FAIL reset_resp got data=%h err=%0b exp 0 0", resp_data, resp_err); end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_write();
    int p0;
    ack_en = 1'b1;
    p0 = stb_pulses;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    checks++; if (wb_cyc !== 1'b1 || wb_stb !== 1'b1 || req_ready !== 1'b0) begin errors++;
      $display("FAIL write_bus_N got cyc=%0b stb=%0b ready=%0b exp 1 1 0", wb_cyc, wb_stb, req_ready); end
    checks++; if (wb_adr !== 32'h10 || wb_datwr !== 32'hDEADBEEF || wb_sel !== 4'hF || wb_we !== 1'b1) begin errors++;
      $display("FAIL write_wb_fields got adr=%h dat=%h sel=%h we=%0b exp 10 deadbeef f 1", wb_adr, wb_datwr, wb_sel, wb_we); end
    @(posedge clock); #1;
    checks++; if (resp_valid !== 1'b0 || wb_stb !== 1'b1 || wb_adr !== 32'h10) begin errors++;
      $display("FAIL write_N1 got rvalid=%0b stb=%0b adr=%h exp 0 1 10", resp_valid, wb_stb, wb_adr); end
    @(posedge clock); #1;
    checks++; if (resp_valid !== 1'b1 || wb_stb !== 1'b0 || wb_cyc !== 1'b0) begin errors++;
      $display("FAIL write_N2 got rvalid=%0b stb=%0b cyc=%0b exp 1 0 0", resp_valid, wb_stb, wb_cyc); end
    checks++; if (resp_data !== 32'h0 || resp_err !== 1'b0) begin errors++;
      $display("FAIL write_resp got data=%h err=%0b exp 0 0", resp_data, resp_err); end
    @(negedge clock); resp_ready = 1'b1;
    @(posedge clock); #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
      $display("FAIL write_release got rvalid=%0b ready=%0b exp 0 1", resp_valid, req_ready); end
    @(negedge clock); resp_ready = 1'b0;
    checks++; if (stb_pulses - p0 !== 1) begin errors++;
      $display("FAIL write_stb_pulses got %0d exp 1", stb_pulses - p0); end
  endtask

  task automatic test_read();
    logic [31:0] rd; logic er; int lat; bit got;
    run_txn(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat, got);
    checks++; if (!got || rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 2) begin errors++;
      $display("FAIL read_full got got=%0b data=%h err=%0b lat=%0d exp 1 deadbeef 0 2", got, rd, er, lat); end
    run_txn(1'b1, 32'h10, 32'h00001234, 4'h3, rd, er, lat, got);
    checks++; if (!got || rd !== 32'h0 || er !== 1'b0) begin errors++;
      $display("FAIL partial_write got got=%0b data=%h err=%0b exp 1 0 0", got, rd, er); end
    run_txn(1'b0, 32'h10, 32'hFFFFFFFF, 4'hF, rd, er, lat, got);
    checks++; if (!got || rd !== 32'hDEAD1234 || er !== 1'b0) begin errors++;
      $display("FAIL read_partial got got=%0b data=%h err=%0b exp 1 dead1234 0", got, rd, er); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic er; int lat; bit got; int h0;
    ack_en = 1'b0;
    h0 = stb_hi;
    run_txn(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat, got);
    checks++; if (!got || er !== 1'b1 || rd !== 32'h0) begin errors++;
      $display("FAIL timeout_resp got got=%0b err=%0b data=%h exp 1 1 0", got, er, rd); end
    checks++; if (stb_hi - h0 !== 16 || lat != 16) begin errors++;
      $display("FAIL timeout_len got stb_cycles=%0d lat=%0d exp 16 16", stb_hi - h0, lat); end
    checks++; if (req_ready !== 1'b1 || wb_cyc !== 1'b0 || resp_valid !== 1'b0) begin errors++;
      $display("FAIL timeout_idle got ready=%0b cyc=%0b rvalid=%0b exp 1 0 0", req_ready, wb_cyc, resp_valid); end
    ack_en = 1'b1;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    issue(1'b0, 32'h10, 32'h0, 4'hF);
    for (int i = 0; i < 8 && !resp_valid; i++) begin @(posedge clock); #1; end
    // hold off the response while offering a competing request
    @(negedge clock); req_valid = 1'b1; req_addr = 32'h20; req_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (resp_valid !== 1'b1 || resp_data !== 32'hDEAD1234 || req_ready !== 1'b0 || wb_stb !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL backpressure_hold got bad_cycles=%0d exp 0 (rvalid=%0b data=%h)", bad, resp_valid, resp_data); end
    @(negedge clock); resp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clock); #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || wb_stb !== 1'b0) begin errors++;
      $display("FAIL backpressure_release got rvalid=%0b ready=%0b stb=%0b exp 0 1 0", resp_valid, req_ready, wb_stb); end
    @(negedge clock); resp_ready = 1'b0;
  endtask

  task automatic test_bus_reset();
    logic [31:0] rd; logic er; int lat; bit got; int bad = 0;
    ack_en = 1'b0;
    issue(1'b1, 32'h18, 32'h55555555, 4'hF);
    checks++; if (wb_stb !== 1'b1) begin errors++;
      $display("FAIL busreset_pre got stb=%0b exp 1", wb_stb); end
    @(negedge clock); reset = 1'b1; ack_en = 1'b1;
    @(posedge clock); #1;
    checks++; if (wb_stb !== 1'b0 || wb_cyc !== 1'b0 || resp_valid !== 1'b0) begin errors++;
      $display("FAIL busreset_drop got stb=%0b cyc=%0b rvalid=%0b exp 0 0 0", wb_stb, wb_cyc, resp_valid); end
    @(negedge clock); reset = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clock); #1; if (resp_valid !== 1'b0 || wb_stb !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL busreset_quiet got bad_cycles=%0d exp 0", bad); end
    run_txn(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat, got);
    checks++; if (!got || rd !== 32'hDEAD1234 || er !== 1'b0 || lat != 2) begin errors++;
      $display("FAIL busreset_after got got=%0b data=%h err=%0b lat=%0d exp 1 dead1234 0 2", got, rd, er, lat); end
  endtask

  task automatic test_stray_ack();
    int h0;
    @(negedge clock); stray = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (req_ready !== 1'b1 || wb_stb !== 1'b0 || resp_valid !== 1'b0) begin errors++;
      $display("FAIL stray_idle got ready=%0b stb=%0b rvalid=%0b exp 1 0 0", req_ready, wb_stb, resp_valid); end
    @(negedge clock); stray = 1'b0; ack_en = 1'b0;
    h0 = stb_hi;
    issue(1'b0, 32'h10, 32'h0, 4'hF);
    repeat (15) @(posedge clock);
    #1;
    checks++; if (resp_valid !== 1'b0 || wb_stb !== 1'b1) begin errors++;
      $display("FAIL edge_pre got rvalid=%0b stb=%0b exp 0 1", resp_valid, wb_stb); end
    @(negedge clock); stray = 1'b1;
    @(posedge clock); #1;
    stray = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_data !== 32'hDEAD1234) begin errors++;
      $display("FAIL ack_at_timeout got rvalid=%0b err=%0b data=%h exp 1 0 dead1234", resp_valid, resp_err, resp_data); end
    checks++; if (stb_hi - h0 !== 16) begin errors++;
      $display("FAIL ack_at_timeout_len got stb_cycles=%0d exp 16", stb_hi - h0); end
    @(negedge clock); resp_ready = 1'b1;
    @(posedge clock); #1;
    @(negedge clock); resp_ready = 1'b0; ack_en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_backpressure();
    test_bus_reset();
    test_stray_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
